mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-stage load/store controller. Consumes the Memory-stage control bundle (`RegWriteM`, `ResultSrcM`, `MemWriteM`) plus address and store data. It runs one data-memory transaction per instruction over a valid/ready request, valid-only response bus. It holds the pipeline with `StallM` until the access completes, and returns aligned, sign- or zero-extended load data to the writeback path. It sits between the Execute→Memory and Memory→Writeback pipeline registers.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data and address width. Only 32 is supported.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `RegWriteM`  in  1  destination register write enable (passed through to `RegWriteOutM`)
- `ResultSrcM`  in  2  `2'b01` = load instruction; any other value = not a load
- `MemWriteM`  in  2  `00` none, `01` SW, `10` SB, `11` SH
- `Funct3M`  in  3  load type: `000` LB, `001` LH, `010` LW, `100` LBU, `101` LHU
- `ALUResultM`  in  32  byte address
- `WriteDataM`  in  32  store data, low-aligned
- `mem_req_valid`  out  1  request valid
- `mem_req_ready`  in  1  request accepted when valid && ready
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  word-aligned address, `{ALUResultM[31:2], 2'b00}`
- `mem_wdata`  out  32  store data shifted into byte lanes
- `mem_be`  out  4  byte enables
- `mem_rsp_valid`  in  1  load response valid
- `mem_rdata`  in  32  load response word
- `StallM`  out  1  holds IF/ID/EX/M stages
- `ReadDataM`  out  32  extended load data; valid in DONE
- `RegWriteOutM`  out  1  `RegWriteM`, gated low on misaligned access
- `MisalignM`  out  1  one-cycle pulse marking a misaligned access

## Operation
- An access is pending when `ResultSrcM==01` or `MemWriteM!=00`.
- If both a load and a store are indicated, the store wins.
- Misaligned accesses are halfword with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - No bus transaction is issued.
  - `MisalignM` pulses for one cycle.
  - The FSM goes IDLE→DONE.
  - `RegWriteOutM` is 0 and `ReadDataM` is 0.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: a pending aligned access → REQ. The request fields are registered from the inputs at this point.
  - REQ: `mem_req_valid=1`. All request fields are held stable until the handshake. On handshake: store → DONE, load → RESP.
  - RESP: wait for `mem_rsp_valid`. Then capture and extend `mem_rdata` into `ReadDataM`, and go to DONE.
  - DONE: `StallM=0`. The pipeline advances at this edge. The FSM unconditionally returns to IDLE, so the same instruction is never re-issued.
- `StallM` = (state is REQ or RESP) || (state is IDLE && access pending).
- Byte enables and lane placement:
  - SB: `be = 1<<addr[1:0]`; the byte is replicated on all lanes.
  - SH: `be = 0011` or `1100`; the halfword is replicated.
  - SW: `be = 1111`.
  - Loads: `be = 1111`, `mem_we = 0`.
- Load extraction: select the byte or half lane by `addr[1:0]`. Sign-extend LB/LH; zero-extend LBU/LHU.
- `mem_rsp_valid` outside RESP is ignored.

## Timing
- Reset values:
  - FSM in IDLE.
  - `mem_req_valid`, `mem_we`, `MisalignM` are 0.
  - `mem_addr`, `mem_wdata`, `mem_be`, `ReadDataM` are 0.
  - `StallM` is combinational; it is 0 while reset is asserted.
- Store, ready held high: C0 IDLE (stall), C1 REQ accepted, C2 DONE. 3 cycles in M.
- Load, ready high, response one cycle later: C0 IDLE, C1 REQ, C2 RESP with `rsp_valid`, C3 DONE. 4 cycles in M.
- Ready low: REQ persists indefinitely with request fields held.
- Back-to-back accesses: the next instruction is seen in IDLE the cycle after DONE.
- Reset mid-transaction: returns to IDLE immediately and drops `mem_req_valid`. A later stray response is ignored.

## Structure
- Package `mem_pkg`:
  - FSM state enum.
  - `MemWrite` encoding constants: `MW_NONE`, `MW_SW`, `MW_SB`, `MW_SH`.
  - Load `Funct3` constants.
  - `RS_MEM = 2'b01`.
- Sub-module `load_extend`: combinational lane select plus sign/zero extension.
- Byte-enable and lane generation stays inline.

## Test plan
- SW to `0x100` with data `0xDEADBEEF`, ready=1:
  - Request: `mem_be=1111`, `mem_addr=0x100`, `mem_wdata=0xDEADBEEF`.
  - `StallM` high for exactly 2 cycles; DONE on the 3rd.
- SB to `0x103` with data `0x000000A5`: `mem_be=1000`, `mem_wdata=0xA5A5A5A5`.
- LB from `0x102`, `mem_rdata=0x12F03456`, response 3 cycles after accept: `ReadDataM=0xFFFFFFF0`; with LBU, `0x000000F0`. Stall is held through all wait cycles.
- LW from `0x106`:
  - No `mem_req_valid`.
  - `MisalignM` pulses once.
  - `RegWriteOutM=0`.
  - DONE one cycle later.
- Ready held low for 5 cycles in REQ: address, data and byte enables stable throughout; a spurious `mem_rsp_valid` before accept is ignored.
- `rst_n` asserted in RESP: outputs are 0 immediately; a subsequent `mem_rsp_valid` does not change `ReadDataM`.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage load/store controller.
// Pure definitions: no latency, no backpressure.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SW   = 2'b01;
    localparam logic [1:0] MW_SB   = 2'b10;
    localparam logic [1:0] MW_SH   = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] RS_MEM = 2'b01;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half lane of a load word and sign- or zero-extends it.
// Purely combinational, zero latency; no backpressure.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   ext = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  ext = {24'd0, byte_sel};
            F3_LHU:  ext = {16'd0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: one bus transaction per instruction, stalls M until done.
// Store 3 cycles, load 4+ cycles in M; request held stable while mem_req_ready is low.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [1:0]            MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  StallM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  RegWriteOutM,
    output logic                  MisalignM
);

    state_t                state_q, state_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  misalign_q, misalign_d;

    logic                  is_store, is_load, pending, misalign;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] load_ext;

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .lane   (lane_q),
        .funct3 (funct3_q),
        .ext    (load_ext)
    );

    // A store indication overrides a simultaneous load indication.
    always_comb begin
        is_store = (MemWriteM != MW_NONE);
        is_load  = !is_store && (ResultSrcM == RS_MEM);
        pending  = is_store || is_load;

        misalign = 1'b0;
        case (MemWriteM)
            MW_SW:   misalign = |ALUResultM[1:0];
            MW_SH:   misalign = ALUResultM[0];
            MW_SB:   misalign = 1'b0;
            default: begin
                if (is_load) begin
                    case (Funct3M)
                        F3_LW:        misalign = |ALUResultM[1:0];
                        F3_LH, F3_LHU: misalign = ALUResultM[0];
                        default:      misalign = 1'b0;
                    endcase
                end
            end
        endcase

        case (MemWriteM)
            MW_SB: begin
                st_be    = 4'b0001 << ALUResultM[1:0];
                st_wdata = {4{WriteDataM[7:0]}};
            end
            MW_SH: begin
                st_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{WriteDataM[15:0]}};
            end
            MW_SW: begin
                st_be    = 4'b1111;
                st_wdata = WriteDataM;
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = '0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        rdata_d     = rdata_q;
        misalign_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    if (misalign) begin
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                        state_d    = ST_DONE;
                    end else begin
                        mem_we_d    = is_store;
                        mem_addr_d  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
                        mem_wdata_d = st_wdata;
                        mem_be_d    = st_be;
                        funct3_d    = Funct3M;
                        lane_d      = ALUResultM[1:0];
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = mem_we_q ? ST_DONE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rsp_valid) begin
                    rdata_d = load_ext;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            funct3_q    <= '0;
            lane_q      <= '0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
        end
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;
    assign ReadDataM     = rdata_q;
    assign MisalignM     = misalign_q;
    assign RegWriteOutM  = RegWriteM && !misalign_q;
    // Forced low under reset so the pipeline is not frozen by a pending access.
    assign StallM        = rst_n && ((state_q == ST_REQ) || (state_q == ST_RESP) ||
                                     ((state_q == ST_IDLE) && pending));

endmodule
